// File: rtl/trs_io_pkg.sv
// Shared types and defaults for the TRS-80 Z80 I/O bus front-end.
package trs_io_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_LATCH,
      ST_RD_WAIT,
      ST_RD_DRIVE,
      ST_HOLD,
      ST_RELEASE
   } io_state_t;

   localparam int unsigned DEF_SYNC_STAGES   = 2;
   localparam int unsigned DEF_SETTLE_CYCLES = 3;
   localparam int unsigned DEF_RD_TIMEOUT    = 255;

   // Value an undriven Z80 data bus reads as.
   localparam logic [7:0] BUS_FLOAT = 8'hFF;

endpackage

// File: rtl/trs_io_bus_if_strobe_sync.sv
// Synchronizer chains for the asynchronous active-low OUT/IN strobes.
module strobe_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic srst_n,
   input  logic i_out_n,
   input  logic i_in_n,
   output logic o_out_n,
   output logic o_in_n
);

   logic [SYNC_STAGES-1:0] r_out_chain;
   logic [SYNC_STAGES-1:0] r_in_chain;

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_out_chain <= '1;
         r_in_chain  <= '1;
      end else begin
         r_out_chain <= {r_out_chain[SYNC_STAGES-2:0], i_out_n};
         r_in_chain  <= {r_in_chain[SYNC_STAGES-2:0], i_in_n};
      end
   end

   assign o_out_n = r_out_chain[SYNC_STAGES-1];
   assign o_in_n  = r_in_chain[SYNC_STAGES-1];

endmodule

// File: rtl/trs_io_bus_if.sv
// Z80 I/O bus front-end: deglitched strobes, latched address/data, one io_access
// per bus cycle, and WAIT-stretched reads driven back from the claiming peripheral.
module trs_io_bus_if
   import trs_io_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned RD_TIMEOUT    = DEF_RD_TIMEOUT
) (
   input  logic       clk,
   input  logic       srst_n,
   input  logic [7:0] bus_a,
   input  logic [7:0] bus_d_in,
   input  logic       bus_out_n,
   input  logic       bus_in_n,
   input  logic       rd_claim,
   input  logic [7:0] rd_data,
   input  logic       rd_rdy,
   output logic [7:0] TRS_A,
   output logic [7:0] TRS_D,
   output logic       TRS_OUT,
   output logic       TRS_IN,
   output logic       io_access,
   output logic [7:0] bus_d_out,
   output logic       bus_d_oe,
   output logic       bus_wait
);

   localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);
   localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

   logic      w_out_n;
   logic      w_in_n;
   logic      w_strb_n;
   logic      w_other_n;
   io_state_t r_state;
   logic      r_is_rd;
   logic [3:0] r_settle;
   logic [7:0] r_timer;

   strobe_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .srst_n  (srst_n),
      .i_out_n (bus_out_n),
      .i_in_n  (bus_in_n),
      .o_out_n (w_out_n),
      .o_in_n  (w_in_n)
   );

   always_comb begin
      w_strb_n  = r_is_rd ? w_in_n  : w_out_n;
      w_other_n = r_is_rd ? w_out_n : w_in_n;
   end

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         r_state   <= ST_IDLE;
         r_is_rd   <= 1'b0;
         r_settle  <= '0;
         r_timer   <= '0;
         TRS_A     <= '0;
         TRS_D     <= '0;
         TRS_OUT   <= 1'b1;
         TRS_IN    <= 1'b1;
         io_access <= 1'b0;
         bus_d_out <= '0;
         bus_d_oe  <= 1'b0;
         bus_wait  <= 1'b0;
      end else begin
         io_access <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!w_out_n && !w_in_n) begin
                  r_state <= ST_RELEASE;
               end else if (!w_out_n || !w_in_n) begin
                  r_is_rd  <= !w_in_n;
                  r_settle <= 4'd1;
                  r_state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!w_other_n) begin
                  r_state <= ST_RELEASE;
               end else if (w_strb_n) begin
                  r_state <= ST_IDLE;
               end else if (r_settle == SETTLE_N) begin
                  // Latch on the exit edge so io_access is high for the whole LATCH cycle.
                  TRS_A <= bus_a;
                  if (r_is_rd) begin
                     TRS_IN <= 1'b0;
                  end else begin
                     TRS_D   <= bus_d_in;
                     TRS_OUT <= 1'b0;
                  end
                  io_access <= 1'b1;
                  r_state   <= ST_LATCH;
               end else begin
                  r_settle <= r_settle + 4'd1;
               end
            end
            ST_LATCH: begin
               // rd_claim decodes the TRS_A registered on the previous edge.
               if (r_is_rd && rd_claim) begin
                  bus_wait <= 1'b1;
                  r_timer  <= '0;
                  r_state  <= ST_RD_WAIT;
               end else begin
                  r_state <= ST_HOLD;
               end
            end
            ST_RD_WAIT: begin
               if (w_strb_n) begin
                  bus_wait <= 1'b0;
                  TRS_OUT  <= 1'b1;
                  TRS_IN   <= 1'b1;
                  r_state  <= ST_RELEASE;
               end else if (rd_rdy) begin
                  bus_d_out <= rd_data;
                  bus_d_oe  <= 1'b1;
                  bus_wait  <= 1'b0;
                  r_state   <= ST_RD_DRIVE;
               end else if (r_timer == TMO_LAST) begin
                  bus_d_out <= BUS_FLOAT;
                  bus_d_oe  <= 1'b1;
                  bus_wait  <= 1'b0;
                  r_state   <= ST_RD_DRIVE;
               end else if (r_timer != 8'hFF) begin
                  r_timer <= r_timer + 8'd1;
               end
            end
            ST_RD_DRIVE: begin
               if (w_strb_n) begin
                  bus_d_oe <= 1'b0;
                  TRS_OUT  <= 1'b1;
                  TRS_IN   <= 1'b1;
                  r_state  <= ST_RELEASE;
               end
            end
            ST_HOLD: begin
               if (w_strb_n) begin
                  TRS_OUT <= 1'b1;
                  TRS_IN  <= 1'b1;
                  r_state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               TRS_OUT  <= 1'b1;
               TRS_IN   <= 1'b1;
               bus_d_oe <= 1'b0;
               bus_wait <= 1'b0;
               if (w_out_n && w_in_n) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
